// File: rtl/rf_read_arbiter_if.sv
// Requester-side bus of the register-file read arbiter: request handshake
// (valid/ready plus register IDs and lock) and the registered response.
// The master modport is the requester side, slave is the arbiter side.
interface rf_read_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 4
);
    logic [NUM_REQ-1:0]          ReqValid;
    logic [NUM_REQ-1:0]          ReqLock;
    logic [NUM_REQ*REG_ID_W-1:0] ReqRegA;
    logic [NUM_REQ*REG_ID_W-1:0] ReqRegB;
    logic [NUM_REQ-1:0]          ReqReady;
    logic [NUM_REQ-1:0]          RespValid;
    logic [DATA_W-1:0]           RespDataA;
    logic [DATA_W-1:0]           RespDataB;

    modport master (
        output ReqValid, ReqLock, ReqRegA, ReqRegB,
        input  ReqReady, RespValid, RespDataA, RespDataB
    );

    modport slave (
        input  ReqValid, ReqLock, ReqRegA, ReqRegB,
        output ReqReady, RespValid, RespDataA, RespDataB
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// Register-file read-port arbiter. NUM_REQ requesters share the two RF read
// ports through a round-robin valid/ready handshake. A requester may lock the
// ports for a burst, bounded by MAX_LOCK consecutive grants; after a timeout
// the previous owner is masked for one arbitration if anyone else is waiting.
// Read data is captured one cycle after the grant.
// Optional build macro RF_ARB_FIXED_PRIO0_EN: requester 0 gets absolute
// priority, never locks, and preempts an active lock.
module rf_read_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_read_arbiter_if.slave    req_if,
    output logic [REG_ID_W-1:0] SrcReg1,
    output logic [REG_ID_W-1:0] SrcReg2,
    input  logic [DATA_W-1:0]   SrcData1,
    input  logic [DATA_W-1:0]   SrcData2,
    output logic                Locked
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [NUM_REQ-1:0] vec_t;
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    // First set bit of req searching upward from ptr, wrapping at NUM_REQ-1.
    function automatic vec_t rr_pick(input vec_t req, input idx_t ptr);
        vec_t pick;
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx_t'(idx)]) begin
                pick[idx_t'(idx)] = 1'b1;
                found             = 1'b1;
            end
        end
        return pick;
    endfunction

    // One-hot to index.
    function automatic idx_t enc(input vec_t v);
        idx_t i;
        i = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[k]) i = idx_t'(k);
        end
        return i;
    endfunction

    // Index to one-hot.
    function automatic vec_t dec(input idx_t i);
        vec_t v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Successor index with wrap-around.
    function automatic idx_t inc(input idx_t i);
        return (int'(i) == NUM_REQ - 1) ? '0 : idx_t'(int'(i) + 1);
    endfunction

    state_t            state_q, state_d;
    idx_t              ptr_q, ptr_d;
    cnt_t              cnt_q, cnt_d;
    idx_t              owner_q, owner_d;
    logic              mask_q, mask_d;
    logic              locked_q, locked_d;
    vec_t              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_a_q, resp_a_d;
    logic [DATA_W-1:0] resp_b_q, resp_b_d;

    vec_t grant;
    vec_t req_eff;
    vec_t others;
    idx_t gnt_idx;
    logic lock_ok;
    logic exit_lock;
    logic preempt;

    // Per-requester register IDs unpacked for the port mux.
    logic [REG_ID_W-1:0] reg_a [NUM_REQ];
    logic [REG_ID_W-1:0] reg_b [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign reg_a[gi] = req_if.ReqRegA[gi*REG_ID_W +: REG_ID_W];
            assign reg_b[gi] = req_if.ReqRegB[gi*REG_ID_W +: REG_ID_W];
        end
    endgenerate

`ifdef RF_ARB_FIXED_PRIO0_EN
    localparam vec_t REQ0 = vec_t'(1);
    assign preempt = req_if.ReqValid[0];
`else
    assign preempt = 1'b0;
`endif

    // Grant selection and next-state for the IDLE/LOCKED arbiter.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        mask_d    = mask_q;
        grant     = '0;
        req_eff   = '0;
        others    = '0;
        gnt_idx   = '0;
        lock_ok   = 1'b0;
        exit_lock = 1'b0;

        case (state_q)
            IDLE: begin
                // The timeout mask only lives for this single arbitration.
                mask_d  = 1'b0;
                others  = req_if.ReqValid & ~dec(owner_q);
                req_eff = (mask_q && (|others)) ? others : req_if.ReqValid;
`ifdef RF_ARB_FIXED_PRIO0_EN
                if (req_if.ReqValid[0]) grant = REQ0;
                else                    grant = rr_pick(req_eff & ~REQ0, ptr_q);
`else
                grant = rr_pick(req_eff, ptr_q);
`endif
                if (|grant) begin
                    gnt_idx = enc(grant);
`ifdef RF_ARB_FIXED_PRIO0_EN
                    // Requester 0 stays outside the rotation.
                    if (gnt_idx != '0) ptr_d = inc(gnt_idx);
                    lock_ok = req_if.ReqLock[gnt_idx] && (gnt_idx != '0);
`else
                    ptr_d   = inc(gnt_idx);
                    lock_ok = req_if.ReqLock[gnt_idx];
`endif
                    if (lock_ok) begin
                        state_d = LOCKED;
                        owner_d = gnt_idx;
                        cnt_d   = cnt_t'(1);
                    end
                end
            end
            default: begin
                if (preempt) begin
                    grant     = vec_t'(1);
                    exit_lock = 1'b1;
                end else if (req_if.ReqValid[owner_q]) begin
                    grant = dec(owner_q);
                    if (cnt_q == cnt_t'(MAX_LOCK - 1)) begin
                        // This grant is the MAX_LOCK-th of the burst.
                        exit_lock = 1'b1;
                        mask_d    = 1'b1;
                    end else if (!req_if.ReqLock[owner_q]) begin
                        exit_lock = 1'b1;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end else begin
                    exit_lock = 1'b1;
                end
                if (exit_lock) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ptr_d   = inc(owner_q);
                end
            end
        endcase
    end

    // Response capture: data holds between grants, valid is a one-cycle pulse.
    always_comb begin
        resp_valid_d = grant;
        resp_a_d     = (|grant) ? SrcData1 : resp_a_q;
        resp_b_d     = (|grant) ? SrcData2 : resp_b_q;
        locked_d     = (state_d == LOCKED);
    end

    // Drive the RF read ports from the granted requester, zero when idle.
    always_comb begin
        SrcReg1 = '0;
        SrcReg2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                SrcReg1 = reg_a[i];
                SrcReg2 = reg_b[i];
            end
        end
    end

    // All arbiter and response state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            owner_q      <= '0;
            mask_q       <= 1'b0;
            locked_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_a_q     <= '0;
            resp_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            mask_q       <= mask_d;
            locked_q     <= locked_d;
            resp_valid_q <= resp_valid_d;
            resp_a_q     <= resp_a_d;
            resp_b_q     <= resp_b_d;
        end
    end

    assign req_if.ReqReady  = grant;
    assign req_if.RespValid = resp_valid_q;
    assign req_if.RespDataA = resp_a_q;
    assign req_if.RespDataB = resp_b_q;
    assign Locked           = locked_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: directed request vectors with hand-computed
// grants; every grant pushes its expected response into a scoreboard that a
// separate monitor drains when RespValid pulses.
module tb_rf_read_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 16;
    localparam int REG_ID_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [REG_ID_W-1:0] SrcReg1, SrcReg2;
    logic [DATA_W-1:0]   SrcData1, SrcData2;
    logic                Locked;

    rf_read_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .REG_ID_W(REG_ID_W)) bus ();

    rf_read_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .MAX_LOCK(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_if(bus),
        .SrcReg1(SrcReg1),
        .SrcReg2(SrcReg2),
        .SrcData1(SrcData1),
        .SrcData2(SrcData2),
        .Locked(Locked)
    );

    always #5 clk = ~clk;

    // Register file model with combinational read.
    logic [DATA_W-1:0] rf1 [16];
    logic [DATA_W-1:0] rf2 [16];
    assign SrcData1 = rf1[SrcReg1];
    assign SrcData2 = rf2[SrcReg2];

    logic [REG_ID_W-1:0] reg_a [NUM_REQ];
    logic [REG_ID_W-1:0] reg_b [NUM_REQ];

    typedef struct packed {
        logic [NUM_REQ-1:0] v;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
    } resp_t;

    resp_t sb_q[$];
    resp_t mon_r;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One request cycle: apply vectors, check grant/ports/lock, push expectation.
    task automatic step(input logic [3:0] v, input logic [3:0] l,
                        input logic [3:0] exp_rdy, input logic exp_lk);
        logic [REG_ID_W-1:0] e1, e2;
        @(posedge clk);
        #1;
        bus.ReqValid = v;
        bus.ReqLock  = l;
        @(negedge clk);
        cyc++;
        e1 = '0;
        e2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_rdy[i]) begin
                e1 = reg_a[i];
                e2 = reg_b[i];
            end
        end
        chk("ReqReady", 32'(bus.ReqReady), 32'(exp_rdy));
        chk("Locked",   32'(Locked),       32'(exp_lk));
        chk("SrcReg1",  32'(SrcReg1),      32'(e1));
        chk("SrcReg2",  32'(SrcReg2),      32'(e2));
        if (exp_rdy != '0) sb_q.push_back('{v: exp_rdy, a: rf1[e1], b: rf2[e2]});
        $display("[TB] cyc %0d valid=%b lock=%b ready=%b locked=%b", cyc, v, l, bus.ReqReady, Locked);
    endtask

    // Monitor: each response pulse must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (bus.RespValid != '0) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected: got RespValid=%b, required no response", bus.RespValid);
            end else begin
                mon_r = sb_q.pop_front();
                chk("RespValid", 32'(bus.RespValid), 32'(mon_r.v));
                chk("RespDataA", 32'(bus.RespDataA), 32'(mon_r.a));
                chk("RespDataB", 32'(bus.RespDataB), 32'(mon_r.b));
                $display("[TB] resp valid=%b A=%h B=%h", bus.RespValid, bus.RespDataA, bus.RespDataB);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [3:0] rdy;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf1[i] = 16'h1000 + 16'(i) * 16'h0111;
            rf2[i] = 16'h8000 + 16'(i) * 16'h0203;
        end
        rf1[3] = 16'h1234;
        rf2[7] = 16'hBEEF;
        reg_a[0] = 4'd3;  reg_b[0] = 4'd7;
        reg_a[1] = 4'd5;  reg_b[1] = 4'd6;
        reg_a[2] = 4'd9;  reg_b[2] = 4'd10;
        reg_a[3] = 4'd12; reg_b[3] = 4'd14;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.ReqRegA[i*REG_ID_W +: REG_ID_W] = reg_a[i];
            bus.ReqRegB[i*REG_ID_W +: REG_ID_W] = reg_b[i];
        end
        bus.ReqValid = '0;
        bus.ReqLock  = '0;
        rst_n        = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst RespValid", 32'(bus.RespValid), 32'h0);
        chk("rst Locked",    32'(Locked),        32'h0);
        chk("rst RespDataA", 32'(bus.RespDataA), 32'h0);
        chk("rst ReqReady",  32'(bus.ReqReady),  32'h0);
        rst_n = 1'b1;

        // Single request from requester 0.
        step(4'b0001, 4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("hold RespDataA", 32'(bus.RespDataA), 32'h1234);
        chk("hold RespDataB", 32'(bus.RespDataB), 32'hBEEF);

`ifdef RF_ARB_FIXED_PRIO0_EN
        // Requester 3 locks, requester 0 preempts, 3 regains via round-robin.
        step(4'b1000, 4'b1000, 4'b1000, 1'b0);
        step(4'b1001, 4'b1000, 4'b0001, 1'b1);
        step(4'b1000, 4'b1000, 4'b1000, 1'b0);
        step(4'b1000, 4'b0000, 4'b1000, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
`else
        // All four valid: rotation starts at pointer 1.
        for (int k = 0; k < 8; k++) begin
            rdy = 4'b0001 << ((k + 1) % 4);
            step(4'b1111, 4'b0000, rdy, 1'b0);
        end
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Requester 2 locks for MAX_LOCK grants while 1 waits, then 1, then 2 relocks.
        step(4'b0110, 4'b0100, 4'b0010, 1'b0);
        step(4'b0110, 4'b0100, 4'b0100, 1'b0);
        for (int k = 0; k < 7; k++) step(4'b0110, 4'b0100, 4'b0100, 1'b1);
        step(4'b0110, 4'b0100, 4'b0010, 1'b0);
        step(4'b0110, 4'b0100, 4'b0100, 1'b0);
        step(4'b0110, 4'b0100, 4'b0100, 1'b1);

        // Owner drops valid: no grant, next arbitration starts at owner+1 = 3.
        step(4'b0010, 4'b0000, 4'b0000, 1'b1);
        step(4'b0111, 4'b0000, 4'b0001, 1'b0);
        step(4'b0110, 4'b0000, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Asynchronous reset in the middle of a locked burst.
        step(4'b1000, 4'b1000, 4'b1000, 1'b0);
        step(4'b1000, 4'b1000, 4'b1000, 1'b1);
        #2;
        rst_n        = 1'b0;
        bus.ReqValid = '0;
        bus.ReqLock  = '0;
        sb_q.delete();
        #1;
        chk("async RespValid", 32'(bus.RespValid), 32'h0);
        chk("async Locked",    32'(Locked),        32'h0);
        chk("async RespDataA", 32'(bus.RespDataA), 32'h0);
        chk("async RespDataB", 32'(bus.RespDataB), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1001, 4'b0000, 4'b0001, 1'b0);

        // Requester 0 cannot break another requester's lock in the default build.
        step(4'b1000, 4'b1000, 4'b1000, 1'b0);
        step(4'b1001, 4'b1000, 4'b1000, 1'b1);
        step(4'b1001, 4'b0000, 4'b1000, 1'b1);
        step(4'b0001, 4'b0000, 4'b0001, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Timeout with the owner as sole requester: it may be regranted and relock.
        step(4'b0100, 4'b0100, 4'b0100, 1'b0);
        for (int k = 0; k < 7; k++) step(4'b0100, 4'b0100, 4'b0100, 1'b1);
        step(4'b0100, 4'b0100, 4'b0100, 1'b0);
        step(4'b0100, 4'b0000, 4'b0100, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
`endif

        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("scoreboard drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
